// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard query and stall/forward response bundle for hazard_scoreboard.
// Defining HAZ_PERF_EN adds the stall_cnt performance counter to the bundle.
interface hazard_scoreboard_if #(
  parameter int unsigned NPORT = 2,
  parameter int unsigned AW    = 5,
  parameter int unsigned TW    = 2
);
  logic                  d_valid;
  logic [NPORT*AW-1:0]   d_rs_addr;
  logic [NPORT*TW-1:0]   d_tuse;
  logic                  d_wr;
  logic [AW-1:0]         d_wr_addr;
  logic [1:0]            d_res;
  logic                  e_flush;
  logic                  stall;
  logic [NPORT*3-1:0]    fwd_d_sel;
  logic [NPORT*3-1:0]    fwd_e_sel;

`ifdef HAZ_PERF_EN
  logic [31:0]           stall_cnt;

  modport master (
    output d_valid, d_rs_addr, d_tuse, d_wr, d_wr_addr, d_res, e_flush,
    input  stall, fwd_d_sel, fwd_e_sel, stall_cnt
  );
  modport slave (
    input  d_valid, d_rs_addr, d_tuse, d_wr, d_wr_addr, d_res, e_flush,
    output stall, fwd_d_sel, fwd_e_sel, stall_cnt
  );
`else
  modport master (
    output d_valid, d_rs_addr, d_tuse, d_wr, d_wr_addr, d_res, e_flush,
    input  stall, fwd_d_sel, fwd_e_sel
  );
  modport slave (
    input  d_valid, d_rs_addr, d_tuse, d_wr, d_wr_addr, d_res, e_flush,
    output stall, fwd_d_sel, fwd_e_sel
  );
`endif
endinterface

// File: rtl/hazard_scoreboard.sv
// Stall and forward-select generator driven by a shadow E/M/W pipeline using Tuse/Tnew.
// Defining HAZ_PERF_EN adds a free-running stall-cycle counter (stall_cnt).
module hazard_scoreboard #(
  parameter int unsigned NPORT = 2,
  parameter int unsigned AW    = 5,
  parameter int unsigned TW    = 2
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave hz
);

  localparam logic [1:0] ResNone = 2'b00;
  localparam logic [1:0] ResAlu  = 2'b01;
  localparam logic [1:0] ResDm   = 2'b10;
  localparam logic [1:0] ResPc   = 2'b11;

  localparam logic [2:0] SelRf   = 3'd0;
  localparam logic [2:0] SelWDm  = 3'd1;
  localparam logic [2:0] SelWPc  = 3'd2;
  localparam logic [2:0] SelWAlu = 3'd3;
  localparam logic [2:0] SelMAlu = 3'd4;
  localparam logic [2:0] SelMPc  = 3'd5;

  typedef struct packed {
    logic          valid;
    logic          wr;
    logic [AW-1:0] addr;
    logic [1:0]    res;
    logic [TW-1:0] tnew;
  } slot_t;

  slot_t               e_q, m_q, w_q;
  slot_t               e_d, m_d, w_d;
  logic [NPORT*AW-1:0] e_src_q, e_src_d;
  logic [NPORT-1:0]    port_hit;
  logic                stall;

  function automatic logic match(slot_t s, logic [AW-1:0] a);
    return s.valid && s.wr && (s.addr != '0) && (s.addr == a);
  endfunction

  // Only the youngest matching slot decides; older copies are stale.
  function automatic logic port_hazard(slot_t e, slot_t m, slot_t w,
                                       logic [AW-1:0] a, logic [TW-1:0] tuse);
    logic hit;
    hit = 1'b0;
    if (tuse != TW'(3) && a != '0) begin
      if (match(e, a))      hit = (e.tnew > tuse);
      else if (match(m, a)) hit = (m.tnew > tuse);
      else if (match(w, a)) hit = (w.tnew > tuse);
    end
    return hit;
  endfunction

  // A DM result in M is not ready yet, so M only forwards PC and ALU results.
  function automatic logic [2:0] fwd_pick(slot_t m, slot_t w, logic [AW-1:0] a);
    logic [2:0] sel;
    sel = SelRf;
    if (match(m, a) && m.res == ResPc)       sel = SelMPc;
    else if (match(m, a) && m.res == ResAlu) sel = SelMAlu;
    else if (match(w, a)) begin
      case (w.res)
        ResPc:   sel = SelWPc;
        ResAlu:  sel = SelWAlu;
        ResDm:   sel = SelWDm;
        default: sel = SelRf;
      endcase
    end
    return sel;
  endfunction

  function automatic logic [TW-1:0] tnew_of(logic [1:0] res);
    logic [TW-1:0] t;
    case (res)
      ResDm:   t = TW'(2);
      ResAlu:  t = TW'(1);
      default: t = '0;
    endcase
    return t;
  endfunction

  function automatic slot_t age(slot_t s);
    slot_t r;
    r = s;
    if (r.tnew != '0) r.tnew = r.tnew - 1'b1;
    return r;
  endfunction

  always_comb begin
    port_hit     = '0;
    hz.fwd_d_sel = '0;
    hz.fwd_e_sel = '0;
    for (int p = 0; p < NPORT; p++) begin
      port_hit[p] = port_hazard(e_q, m_q, w_q, hz.d_rs_addr[p*AW +: AW],
                                hz.d_tuse[p*TW +: TW]);
      hz.fwd_d_sel[p*3 +: 3] = fwd_pick(m_q, w_q, hz.d_rs_addr[p*AW +: AW]);
      hz.fwd_e_sel[p*3 +: 3] = fwd_pick(m_q, w_q, e_src_q[p*AW +: AW]);
    end
    stall = hz.d_valid && (|port_hit);
  end

  assign hz.stall = stall;

  always_comb begin
    e_d     = '0;
    e_src_d = '0;
    if (!stall) begin
      e_d.valid = hz.d_valid;
      e_d.wr    = hz.d_wr;
      e_d.addr  = hz.d_wr_addr;
      e_d.res   = hz.d_res;
      e_d.tnew  = tnew_of(hz.d_res);
      e_src_d   = hz.d_rs_addr;
    end
    m_d = hz.e_flush ? '0 : age(e_q);
    w_d = age(m_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q     <= '0;
      m_q     <= '0;
      w_q     <= '0;
      e_src_q <= '0;
    end else begin
      e_q     <= e_d;
      m_q     <= m_d;
      w_q     <= w_d;
      e_src_q <= e_src_d;
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)      stall_cnt_q <= '0;
    else if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign hz.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-scenario bench for hazard_scoreboard: expected outputs are queued when each D-stage
// cycle is driven and compared at the following falling edge.
module tb_hazard_scoreboard;

  localparam int unsigned NPORT = 2;
  localparam int unsigned AW    = 5;
  localparam int unsigned TW    = 2;

  localparam logic [1:0] RN = 2'b00;
  localparam logic [1:0] RA = 2'b01;
  localparam logic [1:0] RD = 2'b10;
  localparam logic [1:0] RP = 2'b11;

  typedef struct packed {
    int unsigned id;
    logic        stall;
    logic [2:0]  d0, d1, e0, e1;
    logic        chk_cnt;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc_n = 0;
  exp_t        exp_q[$];
  exp_t        cur;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NPORT(NPORT), .AW(AW), .TW(TW)) hz ();

  hazard_scoreboard #(.NPORT(NPORT), .AW(AW), .TW(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One D-stage cycle: drive inputs just after the edge and queue the expected response.
  task automatic cyc(input logic v, input logic [4:0] rs0, input logic [1:0] tu0,
                     input logic [4:0] rs1, input logic [1:0] tu1, input logic wr,
                     input logic [4:0] wa, input logic [1:0] res, input logic fl,
                     input logic rst, input logic xs, input logic [2:0] xd0,
                     input logic [2:0] xd1, input logic [2:0] xe0, input logic [2:0] xe1);
    exp_t e;
    @(posedge clk);
    #1;
    hz.d_valid   = v;
    hz.d_rs_addr = {rs1, rs0};
    hz.d_tuse    = {tu1, tu0};
    hz.d_wr      = wr;
    hz.d_wr_addr = wa;
    hz.d_res     = res;
    hz.e_flush   = fl;
    reset        = rst;
    cyc_n++;
    e = '{id: cyc_n, stall: xs, d0: xd0, d1: xd1, e0: xe0, e1: xe1, chk_cnt: 1'b0, cnt: '0};
    exp_q.push_back(e);
  endtask

  task automatic expect_cnt(input logic [31:0] v);
    exp_t e;
    e = exp_q.pop_back();
    e.chk_cnt = 1'b1;
    e.cnt     = v;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      check_eq($sformatf("c%0d stall", cur.id), 32'(hz.stall), 32'(cur.stall));
      check_eq($sformatf("c%0d fwd_d_sel0", cur.id), 32'(hz.fwd_d_sel[2:0]), 32'(cur.d0));
      check_eq($sformatf("c%0d fwd_d_sel1", cur.id), 32'(hz.fwd_d_sel[5:3]), 32'(cur.d1));
      check_eq($sformatf("c%0d fwd_e_sel0", cur.id), 32'(hz.fwd_e_sel[2:0]), 32'(cur.e0));
      check_eq($sformatf("c%0d fwd_e_sel1", cur.id), 32'(hz.fwd_e_sel[5:3]), 32'(cur.e1));
`ifdef HAZ_PERF_EN
      if (cur.chk_cnt) check_eq($sformatf("c%0d stall_cnt", cur.id), hz.stall_cnt, cur.cnt);
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    hz.d_valid   = 1'b0;
    hz.d_rs_addr = '0;
    hz.d_tuse    = '1;
    hz.d_wr      = 1'b0;
    hz.d_wr_addr = '0;
    hz.d_res     = RN;
    hz.e_flush   = 1'b0;
    repeat (2) @(posedge clk);

    //  v rs0 tu rs1 tu wr wa  res fl rst | st d0 d1 e0 e1
    // Load r8, then dependent add: one stall, then W_DM forward into E.
    cyc(1, 0, 3,  0, 3, 1,  8, RD, 0, 0,  0, 0, 0, 0, 0);   // c1
    expect_cnt(0);
    cyc(1, 8, 1,  9, 1, 1, 10, RA, 0, 0,  1, 0, 0, 0, 0);   // c2
    cyc(1, 8, 1,  9, 1, 1, 10, RA, 0, 0,  0, 0, 0, 0, 0);   // c3
    cyc(0, 0, 3,  0, 3, 0,  0, RN, 0, 0,  0, 0, 0, 1, 0);   // c4
    // ALU r3 then beq r3 (tuse 0): one stall, then M_ALU; r10 seen in W.
    cyc(1, 0, 3,  0, 3, 1,  3, RA, 0, 0,  0, 0, 0, 0, 0);   // c5
    cyc(1, 3, 0, 10, 0, 0,  0, RN, 0, 0,  1, 0, 3, 0, 0);   // c6
    cyc(1, 3, 0, 10, 0, 0,  0, RN, 0, 0,  0, 4, 0, 0, 0);   // c7
    // jal r31 followed by two readers of r31.
    cyc(1, 0, 3,  0, 3, 1, 31, RP, 0, 0,  0, 0, 0, 3, 0);   // c8
    cyc(1,31, 1,  0, 3, 1,  4, RA, 0, 0,  0, 0, 0, 0, 0);   // c9
    cyc(1, 0, 3, 31, 1, 1,  6, RA, 0, 0,  0, 0, 5, 5, 0);   // c10
    cyc(0, 0, 3,  0, 3, 0,  0, RN, 0, 0,  0, 0, 0, 0, 2);   // c11
    // r0 producer and consumer: never stalls or forwards.
    cyc(1, 0, 3,  0, 3, 1,  0, RA, 0, 0,  0, 0, 0, 0, 0);   // c12
    cyc(1, 0, 0,  0, 0, 1,  7, RA, 0, 0,  0, 0, 0, 0, 0);   // c13
    cyc(0, 0, 3,  0, 3, 0,  0, RN, 0, 0,  0, 0, 0, 0, 0);   // c14
    // Two writers of r5: M copy wins over W copy.
    cyc(1, 0, 3,  0, 3, 1,  5, RA, 0, 0,  0, 0, 0, 0, 0);   // c15
    cyc(1, 0, 3,  0, 3, 1,  5, RA, 0, 0,  0, 0, 0, 0, 0);   // c16
    cyc(1, 5, 1,  0, 3, 1, 12, RA, 0, 0,  0, 4, 0, 0, 0);   // c17
    cyc(1, 5, 0,  5, 1, 1, 11, RA, 0, 0,  0, 4, 4, 4, 0);   // c18
    cyc(0, 0, 3,  0, 3, 0,  0, RN, 0, 0,  0, 0, 0, 3, 3);   // c19
    // Load r9 flushed from E: stall once, no forward afterwards.
    cyc(1, 0, 3,  0, 3, 1,  9, RD, 0, 0,  0, 0, 0, 0, 0);   // c20
    cyc(1, 9, 1,  0, 3, 1, 13, RA, 1, 0,  1, 0, 0, 0, 0);   // c21
    cyc(1, 9, 1,  0, 3, 1, 13, RA, 0, 0,  0, 0, 0, 0, 0);   // c22
    cyc(0, 0, 3,  0, 3, 0,  0, RN, 0, 0,  0, 0, 0, 0, 0);   // c23
    // Reset during a stall clears the hazard and the counter.
    cyc(1, 0, 3,  0, 3, 1, 14, RD, 0, 0,  0, 0, 0, 0, 0);   // c24
    expect_cnt(3);
    cyc(1,14, 0, 13, 0, 1, 15, RA, 0, 1,  1, 0, 3, 0, 0);   // c25
    cyc(1,14, 0, 13, 0, 1, 15, RA, 0, 0,  0, 0, 0, 0, 0);   // c26
    expect_cnt(0);
    // Hazard present but D holds no instruction: no stall.
    cyc(0,15, 0,  0, 3, 0,  0, RN, 0, 0,  0, 0, 0, 0, 0);   // c27

    @(negedge clk);
    #1;
    check_eq("queue drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
